// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases reset domains in order after a synchronised reset release, then runs an init handshake with a timeout.
`timescale 1ns/1ps
module rst_seq_ctrl #(
  parameter int NUM_STAGES   = 4,
  parameter int STAGE_GAP    = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int INIT_TIMEOUT = 1024
) (
  input  logic                  clk_tb,
  input  logic                  rst,
  input  logic                  sw_rst_req,
  input  logic                  init_ack,
  output logic [NUM_STAGES-1:0] rst_out_n,
  output logic                  init_req,
  output logic                  rst_done,
  output logic                  init_timeout,
  output logic [2:0]            seq_state
);
  localparam int MAXC = STAGE_GAP > INIT_TIMEOUT ? STAGE_GAP : INIT_TIMEOUT;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] GAP_END = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TO_END = CW'(INIT_TIMEOUT - 1);
  typedef enum logic [2:0] {RST = 3'd0, SEQ = 3'd1, INIT = 3'd2, DONE = 3'd3, ERR = 3'd4, HOLD = 3'd5} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic sw_ok;
  assign sw_ok = sw_rst_req && (state == SEQ || state == INIT || state == DONE || state == ERR);
  assign seq_state = state;
  always_ff @(posedge clk_tb or negedge rst) begin
    if (!rst) begin
      state        <= RST;
      cnt          <= '0;
      sync         <= '0;
      rst_out_n    <= '0;
      init_req     <= 1'b0;
      rst_done     <= 1'b0;
      init_timeout <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], 1'b1};
      if (sw_ok) begin
        state        <= HOLD;
        cnt          <= '0;
        rst_out_n    <= '0;
        init_req     <= 1'b0;
        rst_done     <= 1'b0;
        init_timeout <= 1'b0;
      end else begin
        case (state)
          RST: if (sync[SYNC_STAGES-1]) begin
            state     <= SEQ;
            rst_out_n <= NUM_STAGES'(1);
            cnt       <= '0;
          end
          HOLD: if (cnt == GAP_END) begin
            state     <= SEQ;
            rst_out_n <= NUM_STAGES'(1);
            cnt       <= '0;
          end else cnt <= cnt + 1'b1;
          // once the top domain is out, one more full gap elapses before init starts
          SEQ: if (cnt == GAP_END) begin
            cnt <= '0;
            if (rst_out_n[NUM_STAGES-1]) begin
              state    <= INIT;
              init_req <= 1'b1;
            end else rst_out_n <= (rst_out_n << 1) | NUM_STAGES'(1);
          end else cnt <= cnt + 1'b1;
          INIT: if (init_ack) begin
            state    <= DONE;
            init_req <= 1'b0;
            rst_done <= 1'b1;
            cnt      <= '0;
          end else if (cnt == TO_END) begin
            state        <= ERR;
            init_req     <= 1'b0;
            init_timeout <= 1'b1;
            cnt          <= '0;
          end else cnt <= cnt + 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: scoreboard bench; expected output-change events are queued by stimulus and matched by a monitor.
`timescale 1ns/1ps
module tb_rst_seq_ctrl;
  logic clk_tb, rst, sw_rst_req, init_ack;
  logic [3:0] rst_out_n, rst_out_n4;
  logic init_req, rst_done, init_timeout, init_req4, rst_done4, init_timeout4;
  logic [2:0] seq_state, seq_state4;
  rst_seq_ctrl dut (
    .clk_tb(clk_tb), .rst(rst), .sw_rst_req(sw_rst_req), .init_ack(init_ack),
    .rst_out_n(rst_out_n), .init_req(init_req), .rst_done(rst_done),
    .init_timeout(init_timeout), .seq_state(seq_state)
  );
  rst_seq_ctrl #(.INIT_TIMEOUT(4)) dut4 (
    .clk_tb(clk_tb), .rst(rst), .sw_rst_req(sw_rst_req), .init_ack(init_ack),
    .rst_out_n(rst_out_n4), .init_req(init_req4), .rst_done(rst_done4),
    .init_timeout(init_timeout4), .seq_state(seq_state4)
  );
  typedef struct {int e; logic [9:0] v;} ev_t;
  ev_t q[$];
  int ecnt = 0, base = 0, errors = 0, checks = 0;
  logic use4, mon_en;
  logic [9:0] prev, cur;
  logic [9:0] v_main, v_4;
  assign v_main = {seq_state, init_timeout, rst_done, init_req, rst_out_n};
  assign v_4 = {seq_state4, init_timeout4, rst_done4, init_req4, rst_out_n4};
  initial clk_tb = 1'b0;
  always #5 clk_tb = ~clk_tb;
  always @(posedge clk_tb) ecnt <= ecnt + 1;
  function automatic logic [9:0] mk(int s, bit to, bit dn, bit rq, logic [3:0] r);
    logic [2:0] s3;
    s3 = 3'(s);
    return {s3, to, dn, rq, r};
  endfunction
  always begin
    @(negedge clk_tb or negedge rst);
    #1;
    if (mon_en) begin
      cur = use4 ? v_4 : v_main;
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change: edge %0d got %h, no change expected", ecnt - base, cur);
        end else begin
          ev_t e;
          e = q.pop_front();
          if (e.e != ecnt || e.v !== cur) begin
            errors++;
            $display("FAIL event: got edge %0d val %h, expected edge %0d val %h", ecnt - base, cur, e.e - base, e.v);
          end
        end
        prev = cur;
      end
    end
  end
  task automatic push(int rel, logic [9:0] v);
    q.push_back('{base + rel, v});
  endtask
  task automatic at(int n);
    while (ecnt < base + n) @(negedge clk_tb);
  endtask
  task automatic start();
    @(negedge clk_tb);
    rst = 1'b1;
    base = ecnt;
  endtask
  task automatic abort();
    @(posedge clk_tb);
    #1ps;
    q.push_back('{ecnt, 10'd0});
    rst = 1'b0;
    repeat (2) @(negedge clk_tb);
  endtask
  task automatic drain(string name);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d events pending, expected 0", name, q.size());
    end
    q.delete();
  endtask
  task automatic seq_to_init();
    push(3, mk(1, 0, 0, 0, 4'b0001));
    push(11, mk(1, 0, 0, 0, 4'b0011));
    push(19, mk(1, 0, 0, 0, 4'b0111));
    push(27, mk(1, 0, 0, 0, 4'b1111));
    push(35, mk(2, 0, 0, 1, 4'b1111));
  endtask
  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1; sw_rst_req = 1'b0; init_ack = 1'b0; use4 = 1'b0; mon_en = 1'b0; prev = '0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if (v_main !== 10'd0) begin errors++; $display("FAIL reset_state: got %h expected 000", v_main); end
    checks++;
    if (v_4 !== 10'd0) begin errors++; $display("FAIL reset_state4: got %h expected 000", v_4); end
    mon_en = 1'b1;
    // release timing and handshake
    start(); seq_to_init();
    push(40, mk(3, 0, 1, 0, 4'b1111));
    at(39); init_ack = 1'b1; at(40); init_ack = 1'b0;
    at(60); drain("handshake");
    abort();
    // timeout, software reset, ignored request during HOLD
    start(); seq_to_init();
    push(1059, mk(4, 1, 0, 0, 4'b1111));
    push(1100, mk(5, 0, 0, 0, 4'b0000));
    push(1108, mk(1, 0, 0, 0, 4'b0001));
    push(1116, mk(1, 0, 0, 0, 4'b0011));
    push(1124, mk(1, 0, 0, 0, 4'b0111));
    push(1132, mk(1, 0, 0, 0, 4'b1111));
    push(1140, mk(2, 0, 0, 1, 4'b1111));
    at(1099); sw_rst_req = 1'b1; at(1100); sw_rst_req = 1'b0;
    at(1103); sw_rst_req = 1'b1; at(1104); sw_rst_req = 1'b0;
    at(1145); drain("timeout_sw");
    abort();
    // async abort at edge 15 then replay
    start();
    push(3, mk(1, 0, 0, 0, 4'b0001));
    push(11, mk(1, 0, 0, 0, 4'b0011));
    at(14); abort();
    start(); seq_to_init();
    at(45); drain("abort_replay");
    abort();
    // ack stuck high
    init_ack = 1'b1;
    start(); seq_to_init();
    push(36, mk(3, 0, 1, 0, 4'b1111));
    at(50); drain("stuck_ack");
    abort();
    init_ack = 1'b0;
    // short timeout instance: plain timeout, then ack on the timeout cycle
    use4 = 1'b1; prev = v_4;
    start(); seq_to_init();
    push(39, mk(4, 1, 0, 0, 4'b1111));
    at(45); drain("short_timeout");
    abort();
    start(); seq_to_init();
    push(39, mk(3, 0, 1, 0, 4'b1111));
    at(38); init_ack = 1'b1; at(39); init_ack = 1'b0;
    at(45); drain("ack_vs_timeout");
    abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
